// File: rtl/stream_judge.sv
// stream_judge: checks an actual data stream against expected values queued in an
// internal FIFO, keeps match/mismatch statistics and publishes a registered verdict.
module stream_judge #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MAX_ERR = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             done,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             act_valid,
    output logic             act_ready,
    input  logic [WIDTH-1:0] act_data,
    output logic [2:0]       judge,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err
);
    localparam int unsigned      AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      LP_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LP_MAX_ERR = CNT_W'(MAX_ERR);

    localparam logic [2:0] J_IDLE     = 3'b000;
    localparam logic [2:0] J_RUN      = 3'b001;
    localparam logic [2:0] J_PASS     = 3'b010;
    localparam logic [2:0] J_MISMATCH = 3'b011;
    localparam logic [2:0] J_LEFTOVER = 3'b100;
    localparam logic [2:0] J_ABORT    = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [2:0]       r_judge;
    logic [CNT_W-1:0] r_match;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_first;

    logic             w_run;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_hit;
    logic             w_miss;
    logic             w_abort;
    logic [CNT_W:0]   w_idx_sum;
    logic [CNT_W-1:0] w_idx;
    logic [CNT_W-1:0] w_match_nx;
    logic [CNT_W-1:0] w_err_nx;
    logic [AW:0]      w_count_nx;

    always_comb begin
        w_run      = (r_state == S_RUN);
        w_full     = (r_count == LP_DEPTH);
        w_empty    = (r_count == '0);
        act_ready  = w_run && !w_empty;
        w_pop      = act_valid && act_ready;
        // a pop frees a slot in the same cycle, so a full FIFO can still accept
        exp_ready  = w_run && (!w_full || w_pop);
        w_push     = exp_valid && exp_ready;
        w_hit      = (r_mem[r_rd_ptr] == act_data);
        w_miss     = w_pop && !w_hit;
        w_idx_sum  = {1'b0, r_match} + {1'b0, r_err};
        w_idx      = w_idx_sum[CNT_W] ? '1 : w_idx_sum[CNT_W-1:0];
        w_match_nx = (w_pop && w_hit && (r_match != '1)) ? r_match + CNT_W'(1) : r_match;
        w_err_nx   = (w_miss && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;
        w_count_nx = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        w_abort    = (MAX_ERR != 0) && w_miss && (r_err != LP_MAX_ERR) && (w_err_nx == LP_MAX_ERR);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_judge  <= J_IDLE;
            r_match  <= '0;
            r_err    <= '0;
            r_first  <= '1;
        end else begin
            case (r_state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_count  <= '0;
                        r_judge  <= J_RUN;
                        r_match  <= '0;
                        r_err    <= '0;
                        r_first  <= '1;
                    end
                end
                S_RUN: begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                    r_count <= w_count_nx;
                    r_match <= w_match_nx;
                    r_err   <= w_err_nx;
                    if (w_miss && (r_first == '1)) begin
                        r_first <= w_idx;
                    end
                    if (w_abort) begin
                        r_state <= S_FAIL;
                        r_judge <= J_ABORT;
                    end else if (done) begin
                        if (w_err_nx != '0) begin
                            r_state <= S_FAIL;
                            r_judge <= J_MISMATCH;
                        end else if (w_count_nx != '0) begin
                            r_state <= S_FAIL;
                            r_judge <= J_LEFTOVER;
                        end else begin
                            r_state <= S_PASS;
                            r_judge <= J_PASS;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign judge     = r_judge;
    assign match_cnt = r_match;
    assign err_cnt   = r_err;
    assign first_err = r_first;

endmodule

// File: tb/tb_stream_judge.sv
// Randomised scoreboard bench for stream_judge: a queue-based reference model predicts
// every compare and verdict, and a negedge monitor checks them as the DUT presents them.
module tb_stream_judge;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned MAX_ERR = 4;
    localparam int unsigned CNT_W   = 16;

    logic             clk = 1'b0;
    logic             reset_n, start, done;
    logic             exp_valid, exp_ready, act_valid, act_ready;
    logic [WIDTH-1:0] exp_data, act_data;
    logic [2:0]       judge;
    logic [CNT_W-1:0] match_cnt, err_cnt, first_err;

    stream_judge #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .MAX_ERR(MAX_ERR),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .done     (done),
        .exp_valid(exp_valid),
        .exp_ready(exp_ready),
        .exp_data (exp_data),
        .act_valid(act_valid),
        .act_ready(act_ready),
        .act_data (act_data),
        .judge    (judge),
        .match_cnt(match_cnt),
        .err_cnt  (err_cnt),
        .first_err(first_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  j;
        logic [15:0] m;
        logic [15:0] e;
        logic [15:0] f;
    } rec_t;

    rec_t        sb_q[$];
    logic [7:0]  mq[$];
    bit          m_run   = 1'b0;
    bit          m_known = 1'b0;
    logic [2:0]  m_judge = 3'b000;
    int unsigned m_match = 0, m_err = 0, m_first = 32'hFFFF;
    int          errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, "_judge"}, 32'(judge), 32'(m_judge));
        check({tag, "_match"}, 32'(match_cnt), m_match);
        check({tag, "_err"}, 32'(err_cnt), m_err);
        check({tag, "_first"}, 32'(first_err), m_first);
    endtask

    // Reference model: one call per clock edge, working on a plain queue.
    task automatic step(input logic rst_n, input logic st, input logic dn, input logic ev,
                        input logic [7:0] ed, input logic av, input logic [7:0] ad);
        bit fa, fe, miss;
        logic [2:0] prev;
        logic [7:0] e;
        prev = m_judge;
        fa   = rst_n && m_run && (mq.size() > 0) && av;
        fe   = rst_n && m_run && ev && ((mq.size() < DEPTH) || fa);
        miss = 1'b0;
        if (!rst_n) begin
            m_run = 1'b0; mq.delete(); m_match = 0; m_err = 0; m_first = 32'hFFFF;
            m_judge = 3'b000; m_known = 1'b1;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1'b1; mq.delete(); m_match = 0; m_err = 0; m_first = 32'hFFFF;
                m_judge = 3'b001;
            end
        end else begin
            if (fa) begin
                e = mq.pop_front();
                if (e == ad) begin
                    if (m_match < 32'hFFFF) m_match++;
                end else begin
                    miss = 1'b1;
                    if (m_first == 32'hFFFF)
                        m_first = (m_match + m_err > 32'hFFFF) ? 32'hFFFF : m_match + m_err;
                    if (m_err < 32'hFFFF) m_err++;
                end
            end
            if (fe) mq.push_back(ed);
            if (miss && (MAX_ERR != 0) && (m_err == MAX_ERR)) begin
                m_run = 1'b0; m_judge = 3'b101;
            end else if (dn) begin
                m_run = 1'b0;
                m_judge = (m_err != 0) ? 3'b011 : (mq.size() != 0) ? 3'b100 : 3'b010;
            end
        end
        if (fa || (m_judge != prev))
            sb_q.push_back('{m_judge, m_match[15:0], m_err[15:0], m_first[15:0]});
    endtask

    task automatic cycle(input logic rst_n, input logic st, input logic dn, input logic ev,
                         input logic [7:0] ed, input logic av, input logic [7:0] ad);
        bit pa, pe;
        reset_n = rst_n; start = st; done = dn;
        exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad;
        #1;
        pa = m_run && (mq.size() > 0);
        pe = m_run && ((mq.size() < DEPTH) || (av && pa));
        if (m_known) begin
            check("act_ready", 32'(act_ready), 32'(pa));
            check("exp_ready", 32'(exp_ready), 32'(pe));
        end
        @(posedge clk);
        step(rst_n, st, dn, ev, ed, av, ad);
        #1;
    endtask

    task automatic go();                   cycle(1, 1, 0, 0, 8'h00, 0, 8'h00); endtask
    task automatic idle();                 cycle(1, 0, 0, 0, 8'h00, 0, 8'h00); endtask
    task automatic fin();                  cycle(1, 0, 1, 0, 8'h00, 0, 8'h00); endtask
    task automatic push(input logic [7:0] d); cycle(1, 0, 0, 1, d, 0, 8'h00); endtask
    task automatic act(input logic [7:0] d);  cycle(1, 0, 0, 0, 8'h00, 1, d); endtask

    // Monitor: an edge with an act transfer or a verdict change must match the next record.
    initial begin
        bit         last_fire;
        logic [2:0] last_judge;
        rec_t       r;
        last_fire  = 1'b0;
        last_judge = 3'b000;
        forever begin
            @(negedge clk);
            if (last_fire || (judge != last_judge)) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    r = sb_q.pop_front();
                    check("mon_judge", 32'(judge), 32'(r.j));
                    check("mon_match", 32'(match_cnt), 32'(r.m));
                    check("mon_err", 32'(err_cnt), 32'(r.e));
                    check("mon_first", 32'(first_err), 32'(r.f));
                end
            end
            last_fire  = ((reset_n && act_valid && act_ready) === 1'b1);
            last_judge = judge;
        end
    end

    initial begin
        logic [7:0] ad;
        reset_n = 0; start = 0; done = 0;
        exp_valid = 0; exp_data = '0; act_valid = 0; act_data = '0;

        repeat (2) cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                         1'($urandom), 8'($urandom));
        check_out("reset");
        check("reset_first_ones", 32'(first_err), 32'hFFFF);
        idle();

        go();
        push(8'h11); push(8'h22); push(8'h33);
        act(8'h11); act(8'h22); act(8'h33);
        fin();
        check("pass_judge", 32'(judge), 32'h2);
        check("pass_match", 32'(match_cnt), 32'd3);
        check("pass_first", 32'(first_err), 32'hFFFF);

        go();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        act(8'h01); act(8'h07); act(8'h03); act(8'h04);
        fin();
        check("mism_judge", 32'(judge), 32'h3);
        check("mism_counts", {match_cnt, err_cnt}, {16'd3, 16'd1});
        check("mism_first", 32'(first_err), 32'd1);

        go();
        push(8'hA0); push(8'hA1); push(8'hA2);
        act(8'hA0);
        fin();
        check("left_judge", 32'(judge), 32'h4);
        check("left_match", 32'(match_cnt), 32'd1);

        go();
        for (int unsigned i = 0; i < DEPTH; i++) push(8'(i));
        cycle(1, 0, 0, 1, 8'hEE, 0, 8'h00);
        cycle(1, 0, 0, 1, 8'h55, 1, 8'hFF);
        cycle(1, 0, 0, 1, 8'h56, 0, 8'h00);
        repeat (3) act(8'hFF);
        check("abort_judge", 32'(judge), 32'h5);
        check("abort_err", 32'(err_cnt), 32'd4);
        check("abort_first", 32'(first_err), 32'd0);

        go();
        check("restart_judge", 32'(judge), 32'h1);
        check("restart_counts", {match_cnt, err_cnt}, 32'd0);
        check("restart_first", 32'(first_err), 32'hFFFF);
        push(8'h01); act(8'h01); push(8'h02);
        cycle(0, 0, 0, 1, 8'h03, 1, 8'h02);
        check("midreset_judge", 32'(judge), 32'h0);
        check_out("midreset");
        idle();

        for (int r = 0; r < 6; r++) begin
            go();
            for (int c = 0; c < 40; c++) begin
                if ((mq.size() > 0) && ($urandom_range(3) != 0)) ad = mq[0];
                else ad = 8'($urandom);
                cycle(1, 0, 0, 1'($urandom), 8'($urandom), 1'($urandom), ad);
            end
            fin();
            check_out("rand_end");
            idle(); idle();
        end

        repeat (3) idle();
        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
